// File: rtl/exec_pkg.sv
// exec_pkg: shared types for the multi-cycle execute stage.
//   alu_op_e    : 4-bit ALU opcode encoding
//   br_type_e   : 3-bit branch/jump type encoding
//   mul_state_e : iterative multiplier FSM states
//   FWD_*       : operand forwarding-select encoding, fwd_sel() picks it
package exec_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9,
      ALU_MUL  = 4'd10,
      ALU_MULH = 4'd11
   } alu_op_e;

   typedef enum logic [2:0] {
      BR_NONE = 3'd0,
      BR_JAL  = 3'd1,
      BR_JALR = 3'd2,
      BR_BEQ  = 3'd3,
      BR_BNE  = 3'd4,
      BR_BLT  = 3'd5,
      BR_BGE  = 3'd6
   } br_type_e;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_RUN  = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_e;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_WB    = 2'b01;
   localparam logic [1:0] FWD_EXMEM = 2'b10;

   // EX/MEM beats WB; x0 is never a forwarding destination.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic       ex_en,
                                          input logic [4:0] ex_rd,
                                          input logic       wb_en,
                                          input logic [4:0] wb_rd);
      logic [1:0] sel;
      sel = FWD_RF;
      if (ex_en && (ex_rd != 5'd0) && (ex_rd == rs))
         sel = FWD_EXMEM;
      else if (wb_en && (wb_rd != 5'd0) && (wb_rd == rs))
         sel = FWD_WB;
      return sel;
   endfunction

endpackage

// File: rtl/exec_seq_mul.sv
// exec_seq_mul: iterative shift-add unsigned multiplier, one bit per cycle.
// Only instantiated when EXEC_MUL_EN is defined.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : a MUL/MULH is presented and the EX/MEM register can move
//   flush        : abort / block acceptance
//   stall        : holds the finished product in DONE
//   high         : select high half of the product (MULH)
//   a, b         : operands, latched on acceptance
//   accept       : pulse in the acceptance cycle
//   busy         : front-end must hold (acceptance cycle and RUN)
//   done         : product valid (DONE)
//   result       : selected half of the 2*XLEN product
module exec_seq_mul
   import exec_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            flush,
   input  logic            stall,
   input  logic            high,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            accept,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);

   mul_state_e        r_state, w_state_nx;
   logic [CW-1:0]     r_cnt;
   logic [XLEN-1:0]   r_mcand;
   logic [2*XLEN-1:0] r_prod;
   logic              r_high;
   logic [XLEN:0]     w_sum;

   assign accept = (r_state == MUL_IDLE) && start && !flush;

   // Upper half plus the multiplicand when the current multiplier bit is set;
   // the carry lands in the bit shifted in from the top.
   assign w_sum = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_mcand} : '0);

   always_comb begin
      w_state_nx = r_state;
      busy       = 1'b0;
      done       = 1'b0;
      case (r_state)
         MUL_IDLE: begin
            if (accept) begin
               w_state_nx = MUL_RUN;
               busy       = 1'b1;
            end
         end
         MUL_RUN: begin
            busy = 1'b1;
            if (flush)
               w_state_nx = MUL_IDLE;
            else if (r_cnt == CW'(XLEN-1))
               w_state_nx = MUL_DONE;
         end
         MUL_DONE: begin
            done = 1'b1;
            if (flush || !stall)
               w_state_nx = MUL_IDLE;
         end
         default: w_state_nx = MUL_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= MUL_IDLE;
         r_cnt   <= '0;
         r_mcand <= '0;
         r_prod  <= '0;
         r_high  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         if (accept) begin
            r_cnt   <= '0;
            r_mcand <= a;
            r_prod  <= {{XLEN{1'b0}}, b};
            r_high  <= high;
         end else if (r_state == MUL_RUN) begin
            r_cnt  <= r_cnt + CW'(1);
            r_prod <= {w_sum, r_prod[XLEN-1:1]};
         end
      end
   end

   assign result = r_high ? r_prod[2*XLEN-1:XLEN] : r_prod[XLEN-1:0];

endmodule

// File: rtl/exec_stage_mc.sv
// exec_stage_mc: execute stage with two-source forwarding, branch
// resolution and the EX/MEM pipeline register.
// Optional: define EXEC_MUL_EN to build the iterative MUL/MULH unit;
// without it MUL/MULH are illegal ops (result 0) and ex_busy is 0.
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   memory_stall, ex_flush     : hold EX/MEM / kill the op in EX
//   data1, data2, immediate    : RF operands, sign-extended immediate
//   rs1, rs2, rd, pc           : register indices, instruction PC
//   alu_op, alu_src, br_type   : operation controls
//   prev_taken                 : prediction, passed through
//   wb_en_in, mem_in           : control carried into EX/MEM
//   wb_data_5, wb_en_5, rd_5   : WB forwarding source
//   ex_busy                    : upstream must hold its inputs
//   wb_en_3, mem_3, rd_3,
//   alu_result_3, store_data_3 : EX/MEM register
//   br_target, br_taken,
//   br_valid                   : combinational branch resolution
//   br_pc, prev_taken_out      : pass-through
module exec_stage_mc
   import exec_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int SHW          = $clog2(XLEN),
   parameter int RESET_PC_OFS = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            memory_stall,
   input  logic            ex_flush,
   input  logic [XLEN-1:0] data1,
   input  logic [XLEN-1:0] data2,
   input  logic [XLEN-1:0] immediate,
   input  logic [4:0]      rs1,
   input  logic [4:0]      rs2,
   input  logic [4:0]      rd,
   input  logic [XLEN-1:0] pc,
   input  logic [3:0]      alu_op,
   input  logic            alu_src,
   input  logic [2:0]      br_type,
   input  logic            prev_taken,
   input  logic            wb_en_in,
   input  logic [1:0]      mem_in,
   input  logic [XLEN-1:0] wb_data_5,
   input  logic            wb_en_5,
   input  logic [4:0]      rd_5,
   output logic            ex_busy,
   output logic            wb_en_3,
   output logic [1:0]      mem_3,
   output logic [4:0]      rd_3,
   output logic [XLEN-1:0] alu_result_3,
   output logic [XLEN-1:0] store_data_3,
   output logic [XLEN-1:0] br_target,
   output logic            br_taken,
   output logic            br_valid,
   output logic [XLEN-1:0] br_pc,
   output logic            prev_taken_out
);

   logic            r_wb_en_3;
   logic [1:0]      r_mem_3;
   logic [4:0]      r_rd_3;
   logic [XLEN-1:0] r_alu_result_3;
   logic [XLEN-1:0] r_store_data_3;

   logic [1:0]      w_sel_a, w_sel_b;
   logic [XLEN-1:0] w_fwd_a, w_fwd_b, w_op_b;
   logic [SHW-1:0]  w_shamt;
   logic [XLEN-1:0] w_alu, w_res, w_pc4, w_pc_imm, w_jalr_sum;
   logic            w_is_jump, w_cond;
   logic            w_busy;

   // ---------------- forwarding ----------------
   assign w_sel_a = fwd_sel(rs1, r_wb_en_3, r_rd_3, wb_en_5, rd_5);
   assign w_sel_b = fwd_sel(rs2, r_wb_en_3, r_rd_3, wb_en_5, rd_5);

   assign w_fwd_a = (w_sel_a == FWD_EXMEM) ? r_alu_result_3 :
                    (w_sel_a == FWD_WB)    ? wb_data_5      : data1;
   assign w_fwd_b = (w_sel_b == FWD_EXMEM) ? r_alu_result_3 :
                    (w_sel_b == FWD_WB)    ? wb_data_5      : data2;
   assign w_op_b  = alu_src ? immediate : w_fwd_b;
   assign w_shamt = w_op_b[SHW-1:0];

   // ---------------- ALU ----------------
   always_comb begin
      w_alu = '0;
      case (alu_op)
         ALU_ADD:  w_alu = w_fwd_a + w_op_b;
         ALU_SUB:  w_alu = w_fwd_a - w_op_b;
         ALU_AND:  w_alu = w_fwd_a & w_op_b;
         ALU_OR:   w_alu = w_fwd_a | w_op_b;
         ALU_XOR:  w_alu = w_fwd_a ^ w_op_b;
         ALU_SLL:  w_alu = w_fwd_a << w_shamt;
         ALU_SRL:  w_alu = w_fwd_a >> w_shamt;
         ALU_SRA:  w_alu = $unsigned($signed(w_fwd_a) >>> w_shamt);
         ALU_SLT:  w_alu = {{(XLEN-1){1'b0}}, ($signed(w_fwd_a) < $signed(w_op_b))};
         ALU_SLTU: w_alu = {{(XLEN-1){1'b0}}, (w_fwd_a < w_op_b)};
         default:  w_alu = '0;   // illegal ops, and MUL/MULH on the single-cycle path
      endcase
   end

   assign w_pc4      = pc + XLEN'(RESET_PC_OFS);
   assign w_pc_imm   = pc + immediate;
   assign w_jalr_sum = w_fwd_a + immediate;
   assign w_is_jump  = (br_type == BR_JAL) || (br_type == BR_JALR);
   assign w_res      = w_is_jump ? w_pc4 : w_alu;

   // ---------------- branch resolution ----------------
   always_comb begin
      w_cond = 1'b0;
      case (br_type)
         BR_BEQ:  w_cond = (w_fwd_a == w_op_b);
         BR_BNE:  w_cond = (w_fwd_a != w_op_b);
         BR_BLT:  w_cond = ($signed(w_fwd_a) <  $signed(w_op_b));
         BR_BGE:  w_cond = ($signed(w_fwd_a) >= $signed(w_op_b));
         default: w_cond = 1'b0;
      endcase
   end

   always_comb begin
      br_target = w_pc4;
      if (br_type == BR_JAL)
         br_target = w_pc_imm;
      else if (br_type == BR_JALR)
         br_target = {w_jalr_sum[XLEN-1:1], 1'b0};
      else if (w_cond)
         br_target = w_pc_imm;
   end

   assign br_taken       = w_is_jump || w_cond;
   assign br_valid       = (br_type != 3'd0) && !w_busy;
   assign br_pc          = pc;
   assign prev_taken_out = prev_taken;
   assign ex_busy        = w_busy;

   // ---------------- multiplier ----------------
`ifdef EXEC_MUL_EN
   logic            w_is_mul, w_mul_acc, w_done;
   logic [XLEN-1:0] w_mul_res;
   logic            r_m_wb_en;
   logic [1:0]      r_m_mem;
   logic [4:0]      r_m_rd;
   logic [XLEN-1:0] r_m_store;

   assign w_is_mul = (alu_op == ALU_MUL) || (alu_op == ALU_MULH);

   exec_seq_mul #(.XLEN(XLEN)) u_mul (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (w_is_mul && !memory_stall),
      .flush  (ex_flush),
      .stall  (memory_stall),
      .high   (alu_op == ALU_MULH),
      .a      (w_fwd_a),
      .b      (w_op_b),
      .accept (w_mul_acc),
      .busy   (w_busy),
      .done   (w_done),
      .result (w_mul_res)
   );

   // Control and store data are captured at acceptance: forwarding sources
   // drift while the multiply runs, so re-reading them later is wrong.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_m_wb_en <= 1'b0;
         r_m_mem   <= '0;
         r_m_rd    <= '0;
         r_m_store <= '0;
      end else if (w_mul_acc) begin
         r_m_wb_en <= wb_en_in;
         r_m_mem   <= mem_in;
         r_m_rd    <= rd;
         r_m_store <= w_fwd_b;
      end
   end
`else
   assign w_busy = 1'b0;
`endif

   // ---------------- EX/MEM register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wb_en_3      <= 1'b0;
         r_mem_3        <= '0;
         r_rd_3         <= '0;
         r_alu_result_3 <= '0;
         r_store_data_3 <= '0;
      end else if (!memory_stall) begin
         if (ex_flush || w_busy) begin
            r_wb_en_3      <= 1'b0;
            r_mem_3        <= '0;
            r_rd_3         <= '0;
            r_alu_result_3 <= '0;
            r_store_data_3 <= '0;
`ifdef EXEC_MUL_EN
         end else if (w_done) begin
            r_wb_en_3      <= r_m_wb_en;
            r_mem_3        <= r_m_mem;
            r_rd_3         <= r_m_rd;
            r_alu_result_3 <= w_mul_res;
            r_store_data_3 <= r_m_store;
`endif
         end else begin
            r_wb_en_3      <= wb_en_in;
            r_mem_3        <= mem_in;
            r_rd_3         <= rd;
            r_alu_result_3 <= w_res;
            r_store_data_3 <= w_fwd_b;
         end
      end
   end

   assign wb_en_3      = r_wb_en_3;
   assign mem_3        = r_mem_3;
   assign rd_3         = r_rd_3;
   assign alu_result_3 = r_alu_result_3;
   assign store_data_3 = r_store_data_3;

endmodule

// File: tb/tb_exec_stage_mc.sv
`timescale 1ns/1ps
module tb_exec_stage_mc;
   import exec_pkg::*;

   localparam int XLEN = 32;

   logic            clk = 1'b0, rst_n = 1'b0, memory_stall = 1'b0, ex_flush = 1'b0;
   logic [XLEN-1:0] data1 = '0, data2 = '0, immediate = '0, pc = '0, wb_data_5 = '0;
   logic [4:0]      rs1 = '0, rs2 = '0, rd = '0, rd_5 = '0;
   logic [3:0]      alu_op = '0;
   logic            alu_src = 1'b0, prev_taken = 1'b0, wb_en_in = 1'b0, wb_en_5 = 1'b0;
   logic [2:0]      br_type = '0;
   logic [1:0]      mem_in = '0;

   logic            ex_busy, wb_en_3, br_taken, br_valid, prev_taken_out;
   logic [1:0]      mem_3;
   logic [4:0]      rd_3;
   logic [XLEN-1:0] alu_result_3, store_data_3, br_target, br_pc;

   exec_stage_mc #(.XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n), .memory_stall(memory_stall), .ex_flush(ex_flush),
      .data1(data1), .data2(data2), .immediate(immediate),
      .rs1(rs1), .rs2(rs2), .rd(rd), .pc(pc),
      .alu_op(alu_op), .alu_src(alu_src), .br_type(br_type), .prev_taken(prev_taken),
      .wb_en_in(wb_en_in), .mem_in(mem_in),
      .wb_data_5(wb_data_5), .wb_en_5(wb_en_5), .rd_5(rd_5),
      .ex_busy(ex_busy), .wb_en_3(wb_en_3), .mem_3(mem_3), .rd_3(rd_3),
      .alu_result_3(alu_result_3), .store_data_3(store_data_3),
      .br_target(br_target), .br_taken(br_taken), .br_valid(br_valid),
      .br_pc(br_pc), .prev_taken_out(prev_taken_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        bub;   // only the control fields are defined for a bubble
      logic        wb;
      logic [1:0]  mem;
      logic [4:0]  rd;
      logic [31:0] res;
      logic [31:0] st;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   logic ld_flag = 1'b0;

   function automatic exp_t E(input logic w, input logic [1:0] m, input logic [4:0] r,
                              input logic [31:0] res, input logic [31:0] st);
      exp_t e;
      e.bub = 1'b0; e.wb = w; e.mem = m; e.rd = r; e.res = res; e.st = st;
      return e;
   endfunction

   function automatic exp_t BUB();
      exp_t e;
      e = '0;
      e.bub = 1'b1;
      return e;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   always @(posedge clk) ld_flag <= rst_n && !memory_stall;

   always @(negedge clk) begin
      exp_t e;
      logic ok;
      if (ld_flag) begin
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL exmem_unexpected_load actual rd=%0d res=%h expected no load", rd_3, alu_result_3);
         end else begin
            e = q.pop_front();
            if (e.bub)
               ok = (wb_en_3 === 1'b0) && (mem_3 === 2'd0) && (rd_3 === 5'd0);
            else
               ok = (wb_en_3 === e.wb) && (mem_3 === e.mem) && (rd_3 === e.rd) &&
                    (alu_result_3 === e.res) && (store_data_3 === e.st);
            if (!ok) begin
               failures++;
               $display("FAIL exmem actual wb=%0d mem=%0d rd=%0d res=%h st=%h expected bub=%0d wb=%0d mem=%0d rd=%0d res=%h st=%h",
                        wb_en_3, mem_3, rd_3, alu_result_3, store_data_3,
                        e.bub, e.wb, e.mem, e.rd, e.res, e.st);
            end
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic setop(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic src, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] d, input logic we);
      alu_op = op; data1 = a; data2 = b; immediate = im; alu_src = src;
      rs1 = r1; rs2 = r2; rd = d; wb_en_in = we; br_type = 3'd0; mem_in = 2'd0;
   endtask

   task automatic settle();
      @(negedge clk);
   endtask

   // Push the expectation only when the coming edge actually loads EX/MEM.
   task automatic fin(input exp_t e);
      if (rst_n && !memory_stall) q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic go(input exp_t e);
      settle();
      fin(e);
   endtask

   task automatic alu_case(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res);
      setop(op, a, b, 32'd0, 1'b0, 5'd0, 5'd0, 5'd8, 1'b1);
      go(E(1'b1, 2'd0, 5'd8, res, b));
   endtask

   task automatic br_case(input string nm, input logic [2:0] bt, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] im, input logic [31:0] tgt,
                          input logic tk, input logic we, input logic [31:0] res);
      setop(ALU_ADD, a, b, im, 1'b0, 5'd0, 5'd0, we ? 5'd1 : 5'd0, we);
      br_type = bt; pc = 32'h100; prev_taken = ~prev_taken;
      settle();
      chk({nm, "_target"}, br_target, tgt);
      chk({nm, "_taken"}, br_taken, tk);
      chk({nm, "_valid"}, br_valid, bt != 3'd0);
      chk({nm, "_pc"}, br_pc, 32'h100);
      chk({nm, "_pred"}, prev_taken_out, prev_taken);
      fin(E(we, 2'd0, we ? 5'd1 : 5'd0, res, b));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      // Reset with a live op on the inputs; it becomes the first op after release.
      setop(ALU_ADD, 32'd5, 32'd7, 32'd0, 1'b0, 5'd0, 5'd6, 5'd1, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      settle();
      chk("rst_wb_en", wb_en_3, 0);
      chk("rst_mem", mem_3, 0);
      chk("rst_rd", rd_3, 0);
      chk("rst_result", alu_result_3, 0);
      chk("rst_store", store_data_3, 0);
      chk("rst_busy", ex_busy, 0);
      rst_n = 1'b1;
      fin(E(1'b1, 2'd0, 5'd1, 32'd12, 32'd7));                  // ADD x1 = 5+7

      // Back-to-back hazard: x2 = x1 + 1 via EX/MEM forwarding
      setop(ALU_ADD, 32'd999, 32'd0, 32'd1, 1'b1, 5'd1, 5'd0, 5'd2, 1'b1);
      go(E(1'b1, 2'd0, 5'd2, 32'd13, 32'd0));

      // Both sources hold x3: EX/MEM value (9) must win over WB (4)
      setop(ALU_ADD, 32'd9, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd3, 1'b1);
      go(E(1'b1, 2'd0, 5'd3, 32'd9, 32'd0));
      wb_en_5 = 1'b1; rd_5 = 5'd3; wb_data_5 = 32'd4;
      setop(ALU_ADD, 32'd100, 32'd0, 32'd0, 1'b0, 5'd3, 5'd0, 5'd4, 1'b1);
      go(E(1'b1, 2'd0, 5'd4, 32'd9, 32'd0));
      // A from WB (4), B and store data from EX/MEM x4 (9)
      setop(ALU_ADD, 32'd100, 32'd200, 32'd0, 1'b0, 5'd3, 5'd4, 5'd5, 1'b1);
      go(E(1'b1, 2'd0, 5'd5, 32'd13, 32'd9));
      // x0 as destination never forwards from either stage
      wb_en_5 = 1'b1; rd_5 = 5'd0; wb_data_5 = 32'd77;
      setop(ALU_ADD, 32'd50, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
      go(E(1'b1, 2'd0, 5'd0, 32'd50, 32'd0));
      setop(ALU_ADD, 32'd0, 32'd0, 32'd5, 1'b1, 5'd0, 5'd0, 5'd6, 1'b1);
      mem_in = 2'd2;
      go(E(1'b1, 2'd2, 5'd6, 32'd5, 32'd0));
      wb_en_5 = 1'b0;

      // ALU coverage
      setop(ALU_SLL, 32'd1, 32'h55, 32'h21, 1'b1, 5'd0, 5'd0, 5'd8, 1'b1);
      go(E(1'b1, 2'd0, 5'd8, 32'd2, 32'h55));                   // shamt = 0x21 & 31 = 1
      alu_case(ALU_SRL,  32'h8000_0000, 32'd4, 32'h0800_0000);
      alu_case(ALU_SRA,  32'h8000_0000, 32'd4, 32'hF800_0000);
      alu_case(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0);
      alu_case(ALU_SLT,  32'hFFFF_FFFF, 32'd1, 32'd1);
      alu_case(ALU_SUB,  32'd3, 32'd5, 32'hFFFF_FFFE);
      alu_case(ALU_ADD,  32'hFFFF_FFFF, 32'd2, 32'd1);
      alu_case(ALU_AND,  32'hF0F0, 32'hFF00, 32'hF000);
      alu_case(ALU_OR,   32'hF0F0, 32'hFF00, 32'hFFF0);
      alu_case(ALU_XOR,  32'hF0F0, 32'hFF00, 32'h0FF0);
      alu_case(4'd12,    32'd3, 32'd5, 32'd0);
`ifndef EXEC_MUL_EN
      setop(ALU_MUL, 32'd6, 32'd7, 32'd0, 1'b0, 5'd0, 5'd0, 5'd8, 1'b1);
      settle();
      chk("nomul_busy", ex_busy, 0);
      fin(E(1'b1, 2'd0, 5'd8, 32'd0, 32'd7));
`endif

      // Branch resolution (pc = 0x100)
      br_case("blt",  BR_BLT,  32'hFFFF_FFFF, 32'd1, 32'h20, 32'h120, 1'b1, 1'b0, 32'd0);
      br_case("bge",  BR_BGE,  32'hFFFF_FFFF, 32'd1, 32'h20, 32'h104, 1'b0, 1'b0, 32'd0);
      br_case("beq",  BR_BEQ,  32'd1, 32'd1, 32'h20, 32'h120, 1'b1, 1'b0, 32'd2);
      br_case("bne",  BR_BNE,  32'd1, 32'd1, 32'h20, 32'h104, 1'b0, 1'b0, 32'd2);
      br_case("jalr", BR_JALR, 32'h203, 32'd0, 32'd0, 32'h202, 1'b1, 1'b1, 32'h104);
      br_case("jal",  BR_JAL,  32'd0, 32'd0, 32'h20, 32'h120, 1'b1, 1'b1, 32'h104);
      br_case("none", BR_NONE, 32'd0, 32'd0, 32'h20, 32'h104, 1'b0, 1'b0, 32'd0);
      pc = '0;

      // memory_stall holds the register; flush with stall holds; flush alone bubbles
      setop(ALU_ADD, 32'd20, 32'd22, 32'd0, 1'b0, 5'd0, 5'd0, 5'd9, 1'b1);
      go(E(1'b1, 2'd0, 5'd9, 32'd42, 32'd22));
      memory_stall = 1'b1;
      setop(ALU_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 5'd0, 5'd0, 5'd10, 1'b1);
      go(E(1'b1, 2'd0, 5'd10, 32'd2, 32'd1));
      settle();
      chk("stall_hold_res", alu_result_3, 32'd42);
      chk("stall_hold_rd", rd_3, 5'd9);
      ex_flush = 1'b1;
      fin(BUB());
      settle();
      chk("flush_stall_hold_wb", wb_en_3, 1);
      memory_stall = 1'b0;
      fin(BUB());
      ex_flush = 1'b0;
      setop(ALU_ADD, 32'd2, 32'd3, 32'd0, 1'b0, 5'd0, 5'd0, 5'd11, 1'b1);
      go(E(1'b1, 2'd0, 5'd11, 32'd5, 32'd3));

`ifdef EXEC_MUL_EN
      // MUL / MULH 0xFFFFFFFF * 2 with a stall while DONE
      for (int k = 0; k < 2; k++) begin
         setop(k == 0 ? ALU_MUL : ALU_MULH, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0,
               5'd0, 5'd0, 5'd7, 1'b1);
         settle();
         n = 0;
         while (ex_busy && n < 40) begin
            n++;
            fin(BUB());
            settle();
         end
         chk("mul_busy_cycles", n, 33);
         memory_stall = 1'b1;
         for (int s = 0; s < 2; s++) begin
            fin(BUB());
            settle();
            chk("mul_done_busy", ex_busy, 0);
            chk("mul_done_hold_wb", wb_en_3, 0);
         end
         memory_stall = 1'b0;
         fin(E(1'b1, 2'd0, 5'd7, k == 0 ? 32'hFFFF_FFFE : 32'd1, 32'd2));
         setop(ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
         go(E(1'b0, 2'd0, 5'd0, 32'd0, 32'd0));
      end

      // Flush at RUN count 10 (acceptance cycle + 10 RUN cycles)
      setop(ALU_MUL, 32'd7, 32'd3, 32'd0, 1'b0, 5'd0, 5'd0, 5'd12, 1'b1);
      settle();
      chk("mulf_accept_busy", ex_busy, 1);
      fin(BUB());
      repeat (10) go(BUB());
      ex_flush = 1'b1;
      go(BUB());
      ex_flush = 1'b0;
      setop(ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      settle();
      chk("mulf_idle_busy", ex_busy, 0);
      chk("mulf_wb_en", wb_en_3, 0);
      fin(E(1'b0, 2'd0, 5'd0, 32'd0, 32'd0));
      setop(ALU_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 5'd0, 5'd0, 5'd13, 1'b1);
      go(E(1'b1, 2'd0, 5'd13, 32'd3, 32'd2));

      // Reset during RUN aborts; no product is ever written afterwards
      setop(ALU_MUL, 32'd7, 32'd3, 32'd0, 1'b0, 5'd0, 5'd0, 5'd14, 1'b1);
      repeat (5) go(BUB());
      rst_n = 1'b0;
      setop(ALU_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      go(BUB());
      settle();
      chk("mulr_busy", ex_busy, 0);
      chk("mulr_wb_en", wb_en_3, 0);
      chk("mulr_rd", rd_3, 0);
      chk("mulr_result", alu_result_3, 0);
      rst_n = 1'b1;
      fin(E(1'b0, 2'd0, 5'd0, 32'd0, 32'd0));
      repeat (35) go(E(1'b0, 2'd0, 5'd0, 32'd0, 32'd0));
`endif

      settle();
      #1;
      chk("scoreboard_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
